gb_cpu_bus_ctrl: RTL

//  Memory-bus controller: runs one 8-bit read or write per M-cycle (T1..T4) on the external bus.

---
 rtl/gb_cpu_bus_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/gb_cpu_bus_ctrl.sv
// gb_cpu_bus_ctrl: memory-bus controller for the GB CPU core.
// Runs one 8-bit read or write per M-cycle (T1..T4) on the external bus and
// returns read data to gb_cpu_regfile through its data-bus write port.
// Optional feature macro: GB_CPU_BUS_TIMEOUT_EN (aborts stuck T2 stretches).

package gb_cpu_regfile_pkg;

  typedef enum logic [2:0] {
    R8_B   = 3'd0,
    R8_C   = 3'd1,
    R8_D   = 3'd2,
    R8_E   = 3'd3,
    R8_H   = 3'd4,
    R8_L   = 3'd5,
    R8_HLI = 3'd6,
    R8_A   = 3'd7
  } regfile_r8_t;

  localparam regfile_r8_t REGFILE_R8_RESET = R8_B;

endpackage

module gb_cpu_bus_ctrl
  import gb_cpu_regfile_pkg::*;
`ifdef GB_CPU_BUS_TIMEOUT_EN
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  regfile_r8_t req_dest,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_wait,
  output regfile_r8_t data_bus_req,
  output logic [7:0]  data_bus_data,
  output logic        data_bus_wren,
  output logic        busy,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        ready_state;
  logic        accept;
  logic        strobe_phase;
  logic        write_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  regfile_r8_t dest_q;

`ifdef GB_CPU_BUS_TIMEOUT_EN
  logic [4:0]  wait_cnt_q;
  logic        timeout_hit;
  logic        bus_err_q;
`endif

  assign ready_state  = (state_q == S_IDLE) || (state_q == S_T4);
  assign accept       = req_valid && ready_state;
  assign strobe_phase = (state_q == S_T2) || (state_q == S_T3);

  // State register; reset drops the machine to IDLE immediately, aborting any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed T1..T4 sequence, T2 stretched by bus_wait, T4 may chain into T1.
  always_comb begin
    state_d = state_q;
`ifdef GB_CPU_BUS_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_T1;
        end
      end
      S_T1: begin
        state_d = S_T2;
      end
      S_T2: begin
        if (!bus_wait) begin
          state_d = S_T3;
        end
`ifdef GB_CPU_BUS_TIMEOUT_EN
        else if (wait_cnt_q == 5'(MAX_WAIT)) begin
          timeout_hit = 1'b1;
          state_d     = S_T4;
        end
`endif
      end
      S_T3: begin
        state_d = S_T4;
      end
      S_T4: begin
        state_d = req_valid ? S_T1 : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request fields are captured at accept; read data is captured at the end of T3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      dest_q  <= REGFILE_R8_RESET;
      rdata_q <= 8'h00;
    end else begin
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        dest_q  <= req_dest;
      end
      if ((state_q == S_T3) && !write_q) begin
        rdata_q <= bus_rdata;
      end
`ifdef GB_CPU_BUS_TIMEOUT_EN
      if (timeout_hit && !write_q) begin
        rdata_q <= OPEN_BUS;
      end
`endif
    end
  end

`ifdef GB_CPU_BUS_TIMEOUT_EN
  // Counts stretched T2 cycles so a target that never releases bus_wait cannot hang the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= 5'd0;
    end else if (state_q == S_T1) begin
      wait_cnt_q <= 5'd0;
    end else if ((state_q == S_T2) && bus_wait && !timeout_hit) begin
      wait_cnt_q <= wait_cnt_q + 5'd1;
    end
  end

  // Sticky timeout flag, raised on abort and cleared when the next request is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_err_q <= 1'b0;
    end else if (accept) begin
      bus_err_q <= 1'b0;
    end else if (timeout_hit) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign req_ready     = reset && ready_state;
  assign busy          = (state_q != S_IDLE);
  assign bus_addr      = addr_q;
  assign bus_rd        = strobe_phase && !write_q;
  assign bus_wr        = strobe_phase && write_q;
  assign bus_wdata     = (strobe_phase && write_q) ? wdata_q : 8'h00;
  assign data_bus_req  = dest_q;
  assign data_bus_data = rdata_q;
  assign data_bus_wren = (state_q == S_T4) && !write_q;

endmodule
